// File: rtl/alu_rr_arbiter.sv
// Round-robin front end sharing one external combinational ALU between two command ports.
// Each operation runs accept -> EXEC -> RESP, and the response is held until the owning port takes it.
module alu_rr_arbiter #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [5:0]        req0_opcode,
   input  logic [5:0]        req0_func,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [5:0]        req1_opcode,
   input  logic [5:0]        req1_func,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic              resp0_valid,
   input  logic              resp0_ready,
   output logic              resp1_valid,
   input  logic              resp1_ready,
   output logic [DATA_W-1:0] resp_result,
   output logic              resp_zero,
   output logic              resp_taken,
   output logic [5:0]        alu_opcode,
   output logic [5:0]        alu_func,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   output logic              busy,
   output logic [CNT_W-1:0]  grant_cnt0,
   output logic [CNT_W-1:0]  grant_cnt1
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t            state_reg;
   logic              last_grant_reg;
   logic              owner_reg;
   logic [5:0]        alu_opcode_reg;
   logic [5:0]        alu_func_reg;
   logic [DATA_W-1:0] alu_a_reg;
   logic [DATA_W-1:0] alu_b_reg;
   logic [DATA_W-1:0] resp_result_reg;
   logic              resp_zero_reg;
   logic              resp_taken_reg;
   logic [1:0]        grant;

   // On contention the port that did not win last time goes first.
   always_comb begin
      grant = 2'b00;
      if (state_reg == IDLE) begin
         if (req0_valid && req1_valid) begin
            grant[0] = last_grant_reg;
            grant[1] = !last_grant_reg;
         end else begin
            grant[0] = req0_valid;
            grant[1] = req1_valid;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         last_grant_reg  <= 1'b1;
         owner_reg       <= 1'b0;
         alu_opcode_reg  <= '0;
         alu_func_reg    <= '0;
         alu_a_reg       <= '0;
         alu_b_reg       <= '0;
         resp_result_reg <= '0;
         resp_zero_reg   <= 1'b0;
         resp_taken_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (grant != 2'b00) begin
                  owner_reg      <= grant[1];
                  last_grant_reg <= grant[1];
                  alu_opcode_reg <= grant[1] ? req1_opcode : req0_opcode;
                  alu_func_reg   <= grant[1] ? req1_func   : req0_func;
                  alu_a_reg      <= grant[1] ? req1_a      : req0_a;
                  alu_b_reg      <= grant[1] ? req1_b      : req0_b;
                  state_reg      <= EXEC;
               end
            end
            EXEC: begin
               resp_result_reg <= alu_result;
               resp_zero_reg   <= alu_zero;
               resp_taken_reg  <= (alu_opcode_reg == 6'h04) && alu_zero;
               state_reg       <= RESP;
            end
            RESP: begin
               if (owner_reg ? resp1_ready : resp0_ready)
                  state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Per-port saturating grant counters.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_cnt
         logic [CNT_W-1:0] cnt_reg;
         always_ff @(posedge clk) begin
            if (rst)
               cnt_reg <= '0;
            else if (grant[gi] && (cnt_reg != {CNT_W{1'b1}}))
               cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end
   endgenerate

   assign req0_ready  = grant[0];
   assign req1_ready  = grant[1];
   assign resp0_valid = (state_reg == RESP) && !owner_reg;
   assign resp1_valid = (state_reg == RESP) && owner_reg;
   assign busy        = (state_reg != IDLE);
   assign resp_result = resp_result_reg;
   assign resp_zero   = resp_zero_reg;
   assign resp_taken  = resp_taken_reg;
   assign alu_opcode  = alu_opcode_reg;
   assign alu_func    = alu_func_reg;
   assign alu_a       = alu_a_reg;
   assign alu_b       = alu_b_reg;
   assign grant_cnt0  = g_cnt[0].cnt_reg;
   assign grant_cnt1  = g_cnt[1].cnt_reg;

endmodule
